// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes and memory data-port signals of the arbiter.
// Handshake: a requester raises *_req with stable operands and holds it until
// the one-cycle *_ack; the matching one-cycle *_valid follows on the next
// cycle with *_rdata, which then holds until that requester's next valid.
interface mem_port_arbiter_if #(
  parameter int MEM_WIDTH = 32,
  parameter int AW        = 8
);

  logic                 if_req;
  logic [AW-1:0]        if_addr;
  logic                 if_ack;
  logic                 if_valid;
  logic [MEM_WIDTH-1:0] if_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [AW-1:0]        d_addr;
  logic [MEM_WIDTH-1:0] d_wdata;
  logic                 d_ack;
  logic                 d_valid;
  logic [MEM_WIDTH-1:0] d_rdata;

  logic [AW-1:0]        mem_addr;
  logic                 mem_read_en;
  logic                 mem_write_en;
  logic [MEM_WIDTH-1:0] mem_write_val;
  logic [MEM_WIDTH-1:0] mem_read_val;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_val,
    output if_ack, if_valid, if_rdata, d_ack, d_valid, d_rdata,
           mem_addr, mem_read_en, mem_write_en, mem_write_val
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_val,
    input  if_ack, if_valid, if_rdata, d_ack, d_valid, d_rdata,
           mem_addr, mem_read_en, mem_write_en, mem_write_val
  );

endinterface

// File: rtl/mem_arb_select.sv
// Winner pick between fetch and data requesters plus next starvation count.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter  int STARVE_LIMIT = 4,
  localparam int CW           = cnt_width(STARVE_LIMIT)
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [CW-1:0] starve_cnt,
  output logic          grant,
  output logic          owner,
  output logic [CW-1:0] starve_nxt
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic starved;

  assign starved = (starve_cnt == LIMIT);

  always_comb begin
    grant      = if_req | d_req;
    owner      = OWN_D;
    starve_nxt = '0;
    if (if_req && d_req) begin
      owner = starved ? OWN_IF : OWN_D;
    end else if (if_req) begin
      owner = OWN_IF;
    end
    // Only a data grant that overtakes a waiting fetch advances the count.
    if (if_req && owner == OWN_D) begin
      starve_nxt = starved ? starve_cnt : starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory data port between instruction fetch and load/store,
// data first, with a starvation guard that forces fetch progress.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int MEM_WIDTH    = 32,
  parameter  int MEM_SIZE     = 256,
  parameter  int STARVE_LIMIT = 4,
  localparam int AW           = $clog2(MEM_SIZE),
  localparam int CW           = cnt_width(STARVE_LIMIT)
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output state_e               state_dbg,
  output logic [CW-1:0]        starve_cnt_dbg
);

  state_e               state_q, state_d;
  logic                 arb_en;
  logic                 grant;
  logic                 win_owner;
  logic [CW-1:0]        starve_q, starve_nxt;

  logic                 owner_q;
  logic                 we_q;
  logic [AW-1:0]        addr_q;
  logic [MEM_WIDTH-1:0] wdata_q;
  logic [MEM_WIDTH-1:0] if_rdata_q;
  logic [MEM_WIDTH-1:0] d_rdata_q;

  logic if_ack_q, if_ack_d;
  logic d_ack_q, d_ack_d;
  logic rd_en_q, rd_en_d;
  logic wr_en_q, wr_en_d;
  logic if_valid_q, if_valid_d;
  logic d_valid_q, d_valid_d;

  mem_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .starve_cnt (starve_q),
    .grant      (grant),
    .owner      (win_owner),
    .starve_nxt (starve_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
    end
  end

  // Pulses are computed one cycle ahead so every output leaves a flop.
  always_comb begin
    state_d    = state_q;
    arb_en     = 1'b0;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        arb_en = 1'b1;
        if (grant) begin
          state_d = ISSUE;
          if (win_owner == OWN_IF) begin
            if_ack_d = 1'b1;
            rd_en_d  = 1'b1;
          end else begin
            d_ack_d = 1'b1;
            wr_en_d = bus.d_we;
            rd_en_d = !bus.d_we;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d    = RESP;
        if_valid_d = (owner_q == OWN_IF);
        d_valid_d  = (owner_q == OWN_D);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q   <= '0;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (arb_en) begin
        starve_q <= starve_nxt;
      end
      if (arb_en && grant) begin
        owner_q <= win_owner;
        if (win_owner == OWN_IF) begin
          we_q   <= 1'b0;
          addr_q <= bus.if_addr;
        end else begin
          we_q   <= bus.d_we;
          addr_q <= bus.d_addr;
          if (bus.d_we) begin
            wdata_q <= bus.d_wdata;
          end
        end
      end
      if (state_q == ISSUE) begin
        if (owner_q == OWN_IF) begin
          if_rdata_q <= bus.mem_read_val;
        end else begin
          d_rdata_q <= we_q ? '0 : bus.mem_read_val;
        end
      end
    end
  end

  assign bus.if_ack        = if_ack_q;
  assign bus.if_valid      = if_valid_q;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.d_ack         = d_ack_q;
  assign bus.d_valid       = d_valid_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_read_en   = rd_en_q;
  assign bus.mem_write_en  = wr_en_q;
  assign bus.mem_write_val = wdata_q;

  assign state_dbg      = state_q;
  assign starve_cnt_dbg = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences
// and a randomized phase against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MEM_WIDTH    = 32;
  localparam int MEM_SIZE     = 256;
  localparam int AW           = 8;
  localparam int STARVE_LIMIT = 4;

  logic   clk = 1'b0;
  logic   reset;
  state_e state_dbg;
  logic [2:0] starve_cnt_dbg;

  mem_port_arbiter_if #(.MEM_WIDTH(MEM_WIDTH), .AW(AW)) bus ();

  mem_port_arbiter #(
    .MEM_WIDTH    (MEM_WIDTH),
    .MEM_SIZE     (MEM_SIZE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .state_dbg      (state_dbg),
    .starve_cnt_dbg (starve_cnt_dbg)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  logic [31:0]   mem     [MEM_SIZE];
  logic [31:0]   ref_mem [MEM_SIZE];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;

  always @(posedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_write_val;
    else if (bd_we)       mem[bd_addr]      <= bd_data;
  end

  assign bus.mem_read_val = bus.mem_read_en ? mem[bus.mem_addr] : '0;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  typedef struct packed {
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] last_if;
  logic [31:0] last_d;

  task automatic apply_vec(input vec_t v);
    logic is_st;
    is_st = v.is_d & v.we;
    chk_b("pre_rd_en", bus.mem_read_en, 1'b0);
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    tick();
    chk_b("vec_ack_own", v.is_d ? bus.d_ack : bus.if_ack, 1'b1);
    chk_b("vec_ack_other", v.is_d ? bus.if_ack : bus.d_ack, 1'b0);
    chk_b("vec_rd_en", bus.mem_read_en, !is_st);
    chk_b("vec_wr_en", bus.mem_write_en, is_st);
    chk("vec_mem_addr", 32'(bus.mem_addr), 32'(v.addr));
    if (is_st) begin
      chk("vec_wval", bus.mem_write_val, v.wdata);
      ref_mem[v.addr] = v.wdata;
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    chk_b("vec_valid_own", v.is_d ? bus.d_valid : bus.if_valid, 1'b1);
    chk_b("vec_valid_other", v.is_d ? bus.if_valid : bus.d_valid, 1'b0);
    chk_b("vec_rd_en_off", bus.mem_read_en, 1'b0);
    chk_b("vec_wr_en_off", bus.mem_write_en, 1'b0);
    chk_b("vec_ack_off", bus.if_ack | bus.d_ack, 1'b0);
    if (v.is_d) begin
      chk("vec_d_rdata", bus.d_rdata, v.exp_rdata);
      chk("vec_if_hold", bus.if_rdata, last_if);
      last_d = v.exp_rdata;
    end else begin
      chk("vec_if_rdata", bus.if_rdata, v.exp_rdata);
      chk("vec_d_hold", bus.d_rdata, last_d);
      last_if = v.exp_rdata;
    end
    tick();
    chk_b("vec_valid_off", bus.if_valid | bus.d_valid, 1'b0);
    chk("vec_state", 32'(state_dbg), 32'(IDLE));
  endtask

  // ---------------- model state for randomized phase ----------------
  logic          order_d[10];
  int            skip, m_wait, n_dgr;
  logic          fetch_seen;
  logic          ifr, dr, win_d, e_ifa, e_da, e_rd, e_wr, pv_if, pv_d;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wv;

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    #2 reset = 1'b0;
    #1;
    chk_b("rst_if_ack", bus.if_ack, 1'b0);
    chk_b("rst_d_ack", bus.d_ack, 1'b0);
    chk_b("rst_if_valid", bus.if_valid, 1'b0);
    chk_b("rst_d_valid", bus.d_valid, 1'b0);
    chk_b("rst_rd_en", bus.mem_read_en, 1'b0);
    chk_b("rst_wr_en", bus.mem_write_en, 1'b0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wval", bus.mem_write_val, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_starve", 32'(starve_cnt_dbg), 32'd0);

    // Backdoor preload while the DUT is held in reset.
    for (int i = 0; i < MEM_SIZE; i++) begin
      bd_we = 1'b1; bd_addr = AW'(i);
      bd_data = (i == 212) ? 32'h0000_1825 : init_val(i);
      ref_mem[i] = bd_data;
      tick();
    end
    bd_we = 1'b0;
    reset = 1'b1;
    last_if = '0;
    last_d  = '0;
    tick();
    chk("rel_state", 32'(state_dbg), 32'(IDLE));

    // ---------------- directed table ----------------
    vecs[0] = '{1'b0, 1'b0, 8'd212, 32'h0,         32'h0000_1825};
    vecs[1] = '{1'b1, 1'b1, 8'd5,   32'h0000_00AB, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 8'd5,   32'h0,         32'h0000_00AB};
    vecs[3] = '{1'b0, 1'b0, 8'd5,   32'h0,         32'h0000_00AB};
    vecs[4] = '{1'b1, 1'b1, 8'd255, 32'hDEAD_BEEF, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 8'd255, 32'h0,         32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 1'b0, 8'd0,   32'h0,         32'h1000_0000};
    vecs[7] = '{1'b0, 1'b0, 8'd1,   32'h0,         32'h1001_0003};
    for (int k = 0; k < 8; k++) apply_vec(vecs[k]);

    // ---------------- both requesters held ----------------
    for (int k = 0; k < 10; k++) order_d[k] = ((k % 5) != 4);
    bus.if_req = 1'b1; bus.if_addr = 8'd7;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd8;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c % 2 == 0) begin
        chk_b("sim_grant_d", bus.d_ack, order_d[c/2]);
        chk_b("sim_grant_if", bus.if_ack, !order_d[c/2]);
      end else begin
        chk_b("sim_gap_ack", bus.if_ack | bus.d_ack, 1'b0);
        chk_b("sim_valid_d", bus.d_valid, order_d[c/2]);
        chk_b("sim_valid_if", bus.if_valid, !order_d[c/2]);
        if (order_d[c/2]) chk("sim_d_rdata", bus.d_rdata, ref_mem[8]);
        else              chk("sim_if_rdata", bus.if_rdata, ref_mem[7]);
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick(); tick(); tick();

    // ---------------- fetch idle, then fetch joins ----------------
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd3;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_b("fi_if_ack", bus.if_ack, 1'b0);
      chk_b("fi_d_ack", bus.d_ack, (c % 2) == 0);
      if (c % 2 == 0) chk("fi_starve", 32'(starve_cnt_dbg), 32'd0);
    end
    bus.if_req = 1'b1; bus.if_addr = 8'd9;
    n_dgr = 0;
    fetch_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!fetch_seen) begin
        if (bus.d_ack) begin
          n_dgr++;
          chk("fj_starve", 32'(starve_cnt_dbg), 32'(n_dgr));
        end
        if (bus.if_ack) begin
          fetch_seen = 1'b1;
          chk("fj_starve_clr", 32'(starve_cnt_dbg), 32'd0);
          bus.if_req = 1'b0; bus.d_req = 1'b0;
        end
      end
    end
    chk_b("fj_fetch_seen", fetch_seen, 1'b1);
    chk("fj_dgrants", 32'(n_dgr), 32'd4);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick(); tick();

    // ---------------- async reset during a store ----------------
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'd9; bus.d_wdata = 32'hCAFE_F00D;
    tick();
    chk_b("ar_ack", bus.d_ack, 1'b1);
    chk_b("ar_wr_en", bus.mem_write_en, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_b("ar_wr_en_drop", bus.mem_write_en, 1'b0);
    chk_b("ar_rd_en_drop", bus.mem_read_en, 1'b0);
    chk_b("ar_ack_drop", bus.d_ack | bus.if_ack, 1'b0);
    chk_b("ar_valid_drop", bus.d_valid | bus.if_valid, 1'b0);
    chk("ar_state", 32'(state_dbg), 32'(IDLE));
    bus.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_b("ar_no_valid", bus.d_valid, 1'b0);
      chk_b("ar_no_ack", bus.d_ack, 1'b0);
      chk_b("ar_no_wr", bus.mem_write_en, 1'b0);
    end
    chk("ar_d_rdata", bus.d_rdata, 32'd0);

    // ---------------- withdrawn data request ----------------
    bus.if_req = 1'b1; bus.if_addr = 8'd20;
    tick();
    chk_b("wd_if_ack", bus.if_ack, 1'b1);
    bus.if_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'd21; bus.d_wdata = 32'h1234_5678;
    tick();
    bus.d_req = 1'b0;
    chk_b("wd_if_valid", bus.if_valid, 1'b1);
    chk("wd_if_rdata", bus.if_rdata, ref_mem[20]);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_b("wd_no_d_ack", bus.d_ack, 1'b0);
      chk_b("wd_no_d_valid", bus.d_valid, 1'b0);
      chk_b("wd_no_access", bus.mem_write_en | bus.mem_read_en, 1'b0);
    end

    // ---------------- randomized traffic vs. reference model ----------------
    skip = 0; m_wait = 0; pv_if = 1'b0; pv_d = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ifr = bus.if_req;
      dr  = bus.d_req;
      tick();
      e_ifa = 1'b0; e_da = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wv = '0;
      if (skip != 0) begin
        skip = 0;
      end else begin
        if (!ifr) m_wait = 0;
        if (ifr || dr) begin
          win_d = dr && !(ifr && m_wait >= STARVE_LIMIT);
          if (win_d) begin
            if (ifr && m_wait < STARVE_LIMIT) m_wait++;
            e_da = 1'b1;
            e_addr = bus.d_addr;
            if (bus.d_we) begin
              e_wr = 1'b1; e_wv = bus.d_wdata;
              d_exp_q.push_back(32'h0);
              ref_mem[bus.d_addr] = bus.d_wdata;
            end else begin
              e_rd = 1'b1;
              d_exp_q.push_back(ref_mem[bus.d_addr]);
            end
          end else begin
            m_wait = 0;
            e_ifa = 1'b1; e_rd = 1'b1; e_addr = bus.if_addr;
            if_exp_q.push_back(ref_mem[bus.if_addr]);
          end
          skip = 1;
        end
      end
      chk_b("rnd_if_ack", bus.if_ack, e_ifa);
      chk_b("rnd_d_ack", bus.d_ack, e_da);
      chk_b("rnd_rd_en", bus.mem_read_en, e_rd);
      chk_b("rnd_wr_en", bus.mem_write_en, e_wr);
      if (e_rd || e_wr) chk("rnd_mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      if (e_wr) chk("rnd_wval", bus.mem_write_val, e_wv);
      chk_b("rnd_if_valid", bus.if_valid, pv_if);
      chk_b("rnd_d_valid", bus.d_valid, pv_d);
      if (pv_if && if_exp_q.size() > 0) chk("rnd_if_rdata", bus.if_rdata, if_exp_q.pop_front());
      if (pv_d && d_exp_q.size() > 0)   chk("rnd_d_rdata", bus.d_rdata, d_exp_q.pop_front());
      pv_if = e_ifa;
      pv_d  = e_da;
      if (e_ifa) bus.if_req = 1'b0;
      if (e_da)  bus.d_req  = 1'b0;
      if (!bus.if_req && $urandom_range(0, 2) != 0) begin
        bus.if_req = 1'b1;
        bus.if_addr = AW'($urandom_range(0, 15));
      end
      if (!bus.d_req && $urandom_range(0, 2) != 0) begin
        bus.d_req = 1'b1;
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = AW'($urandom_range(0, 15));
        bus.d_wdata = $urandom;
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick();
    if (pv_if && if_exp_q.size() > 0) chk("rnd_if_rdata", bus.if_rdata, if_exp_q.pop_front());
    if (pv_d && d_exp_q.size() > 0)   chk("rnd_d_rdata", bus.d_rdata, d_exp_q.pop_front());
    tick(); tick();
    chk("rnd_if_q_empty", 32'(if_exp_q.size()), 32'd0);
    chk("rnd_d_q_empty", 32'(d_exp_q.size()), 32'd0);
    chk("end_state", 32'(state_dbg), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
